// File: rtl/fg_mask_filter.sv
`timescale 1ns/1ps
// fg_mask_filter: streaming 3x3 majority filter for the 1-bit foreground mask.
// Define MASK_FILTER_STATS_EN to add the per-frame fg_count output.
module fg_mask_filter #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int THRESH = 5
) (
   input  logic        app_clk,
   input  logic        rst_n,
   input  logic        vid_active_pix,
   input  logic [10:0] vid_hpos,
   input  logic [10:0] vid_vpos,
   input  logic        foregnd_px,
   output logic        filt_valid,
   output logic        filt_px,
   output logic [10:0] filt_hpos,
   output logic [10:0] filt_vpos
`ifdef MASK_FILTER_STATS_EN
   ,
   output logic [18:0] fg_count
`endif
);

   localparam int          AW     = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam logic [10:0] H_LAST = 11'(H_RES - 1);
   localparam logic [10:0] V_LAST = 11'(V_RES - 2);
   localparam logic [3:0]  TH     = 4'(THRESH);

   logic r_lb1 [H_RES];
   logic r_lb2 [H_RES];

   logic [AW-1:0] w_idx;
   logic          w_act;
   logic          w_flush;
   logic          w_top;
   logic          w_mid;
   logic [2:0]    w_col;
   logic          w_first;

   logic [2:0]  r_c0;
   logic [2:0]  r_c1;
   logic [2:0]  r_c2;
   logic        r_pend;
   logic [10:0] r_row;
   logic        r_s1_vld;
   logic [10:0] r_s1_h;
   logic [10:0] r_s1_v;

   logic [3:0]  w_pop;
   logic        w_hit;

   assign w_idx   = vid_hpos[AW-1:0];
   assign w_act   = vid_active_pix && (vid_hpos < 11'(H_RES));
   assign w_flush = r_pend && !w_act;
   assign w_first = (vid_hpos == 11'd0);

   // Rows above the frame read as zero, so stale buffer contents never leak in.
   assign w_top = (vid_vpos >= 11'd2) ? r_lb2[w_idx] : 1'b0;
   assign w_mid = (vid_vpos >= 11'd1) ? r_lb1[w_idx] : 1'b0;
   assign w_col = {w_top, w_mid, foregnd_px};

   always_ff @(posedge app_clk) begin
      if (w_act) begin
         r_lb2[w_idx] <= r_lb1[w_idx];
         r_lb1[w_idx] <= foregnd_px;
      end
   end

   always_ff @(posedge app_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c0     <= '0;
         r_c1     <= '0;
         r_c2     <= '0;
         r_pend   <= 1'b0;
         r_row    <= '0;
         r_s1_vld <= 1'b0;
         r_s1_h   <= '0;
         r_s1_v   <= '0;
      end else begin
         r_pend   <= w_act && (vid_hpos == H_LAST);
         r_s1_vld <= 1'b0;
         if (w_act) begin
            r_c0  <= w_first ? 3'b000 : r_c1;
            r_c1  <= w_first ? 3'b000 : r_c2;
            r_c2  <= w_col;
            r_row <= vid_vpos;
            if (!w_first && vid_vpos != 11'd0) begin
               r_s1_vld <= 1'b1;
               r_s1_h   <= vid_hpos - 11'd1;
               r_s1_v   <= vid_vpos - 11'd1;
            end
         end else if (w_flush) begin
            // Zero column past the right edge completes the last centre.
            r_c0 <= r_c1;
            r_c1 <= r_c2;
            r_c2 <= 3'b000;
            if (r_row != 11'd0) begin
               r_s1_vld <= 1'b1;
               r_s1_h   <= H_LAST;
               r_s1_v   <= r_row - 11'd1;
            end
         end
      end
   end

   assign w_pop = 4'($countones({r_c0, r_c1, r_c2}));
   assign w_hit = (w_pop >= TH);

   always_ff @(posedge app_clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_valid <= 1'b0;
         filt_px    <= 1'b0;
         filt_hpos  <= '0;
         filt_vpos  <= '0;
      end else begin
         filt_valid <= r_s1_vld;
         if (r_s1_vld) begin
            filt_px   <= w_hit;
            filt_hpos <= r_s1_h;
            filt_vpos <= r_s1_v;
         end
      end
   end

`ifdef MASK_FILTER_STATS_EN
   logic [18:0] r_cnt;
   logic [18:0] w_cnt_nxt;
   logic        w_eof;

   assign w_cnt_nxt = (w_hit && r_cnt != '1) ? r_cnt + 19'd1 : r_cnt;
   assign w_eof     = (r_s1_h == H_LAST) && (r_s1_v == V_LAST);

   always_ff @(posedge app_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         fg_count <= '0;
      end else if (r_s1_vld) begin
         if (w_eof) begin
            fg_count <= w_cnt_nxt;
            r_cnt    <= '0;
         end else begin
            r_cnt <= w_cnt_nxt;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fg_mask_filter.sv
`timescale 1ns/1ps
// tb_fg_mask_filter: scoreboard bench for the 3x3 mask filter on a reduced
// 64x48 frame; feature positions are scaled to fit that frame.
module tb_fg_mask_filter;

   localparam int H  = 64;
   localparam int V  = 48;
   localparam int TH = 5;
   localparam int HB = 3;

   logic        app_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vid_active_pix = 1'b0;
   logic [10:0] vid_hpos = '0;
   logic [10:0] vid_vpos = '0;
   logic        foregnd_px = 1'b0;
   logic        filt_valid;
   logic        filt_px;
   logic [10:0] filt_hpos;
   logic [10:0] filt_vpos;
`ifdef MASK_FILTER_STATS_EN
   logic [18:0] fg_count;
`endif

   always #20 app_clk = ~app_clk;

   fg_mask_filter #(.H_RES(H), .V_RES(V), .THRESH(TH)) dut (
      .app_clk        (app_clk),
      .rst_n          (rst_n),
      .vid_active_pix (vid_active_pix),
      .vid_hpos       (vid_hpos),
      .vid_vpos       (vid_vpos),
      .foregnd_px     (foregnd_px),
      .filt_valid     (filt_valid),
      .filt_px        (filt_px),
      .filt_hpos      (filt_hpos),
      .filt_vpos      (filt_vpos)
`ifdef MASK_FILTER_STATS_EN
      ,
      .fg_count       (fg_count)
`endif
   );

   typedef struct {
      bit px;
      int x;
      int y;
      int exp_cyc;
      bit care;
   } exp_t;

   typedef struct {
      int pat;
      int x;
      int y;
      bit px;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[15];
   bit   img[V][H];
   bit   out_img[V][H];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   n_out = 0;
   bit   px_care = 1'b1;

   always @(posedge app_clk) cyc++;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bit gold(input int x, input int y);
      int s = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            if (x + dx >= 0 && x + dx < H && y + dy >= 0 && y + dy < V)
               s += int'(img[y + dy][x + dx]);
      return s >= TH;
   endfunction

   always @(posedge app_clk) begin
      exp_t e;
      int   ox;
      int   oy;
      #1;
      if (filt_valid) begin
         ox = int'(filt_hpos);
         oy = int'(filt_vpos);
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got (%0d,%0d), expected none", ox, oy);
         end else begin
            e = sbq.pop_front();
            chk("out_x", ox, e.x);
            chk("out_y", oy, e.y);
            chk("latency", cyc, e.exp_cyc);
            if (e.care) chk("out_px", int'(filt_px), int'(e.px));
            if (ox < H && oy < V) out_img[oy][ox] = filt_px;
            n_out++;
         end
      end
   end

   task automatic drive_px(input int x, input int y);
      @(negedge app_clk);
      vid_active_pix = 1'b1;
      vid_hpos       = 11'(x);
      vid_vpos       = 11'(y);
      foregnd_px     = img[y][x];
      if (x >= 1 && y >= 1)
         sbq.push_back('{gold(x - 1, y - 1), x - 1, y - 1, cyc + 2, px_care});
      if (x == H - 1 && y >= 1)
         sbq.push_back('{gold(H - 1, y - 1), H - 1, y - 1, cyc + 3, px_care});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge app_clk);
         vid_active_pix = 1'b0;
         foregnd_px     = 1'b0;
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"}, int'(filt_valid), 0);
      chk({tag, "_px"}, int'(filt_px), 0);
      chk({tag, "_hpos"}, int'(filt_hpos), 0);
      chk({tag, "_vpos"}, int'(filt_vpos), 0);
`ifdef MASK_FILTER_STATS_EN
      chk({tag, "_fgcnt"}, int'(fg_count), 0);
`endif
   endtask

   task automatic do_reset();
      @(negedge app_clk);
      vid_active_pix = 1'b0;
      #5 rst_n = 1'b0;
      #1;
      chk_zero_outputs("midrst");
      sbq.delete();
      px_care = 1'b0;
      @(negedge app_clk);
      rst_n = 1'b1;
   endtask

   task automatic run_frame(input int rr, input int rc);
      n_out   = 0;
      px_care = 1'b1;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            out_img[y][x] = 1'b0;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            if (y == rr && x == rc) do_reset();
            drive_px(x, y);
         end
         idle(HB);
      end
      idle(4);
      chk("sb_empty", sbq.size(), 0);
      if (rr < 0) chk("n_out", n_out, H * (V - 1));
   endtask

   task automatic set_pat(input int p);
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++)
            case (p)
               0:       img[y][x] = 1'b1;
               1:       img[y][x] = (x == 20 && y == 10);
               2:       img[y][x] = (x >= 30 && x <= 32 && y >= 20 && y <= 22);
               3:       img[y][x] = !(x == 30 && y == 20);
               default: img[y][x] = ($urandom_range(0, 99) < 55);
            endcase
   endtask

`ifdef MASK_FILTER_STATS_EN
   function automatic int gold_count();
      int s = 0;
      for (int y = 0; y < V - 1; y++)
         for (int x = 0; x < H; x++)
            s += int'(gold(x, y));
      return s;
   endfunction
   int stat_exp[4] = '{3006, 0, 5, 3006};
`endif

   initial begin
      tbl[0]  = '{0, 0, 0, 1'b0};
      tbl[1]  = '{0, 63, 0, 1'b0};
      tbl[2]  = '{0, 1, 0, 1'b1};
      tbl[3]  = '{0, 0, 46, 1'b1};
      tbl[4]  = '{0, 63, 46, 1'b1};
      tbl[5]  = '{0, 32, 20, 1'b1};
      tbl[6]  = '{1, 20, 10, 1'b0};
      tbl[7]  = '{1, 19, 9, 1'b0};
      tbl[8]  = '{1, 21, 11, 1'b0};
      tbl[9]  = '{2, 31, 21, 1'b1};
      tbl[10] = '{2, 31, 20, 1'b1};
      tbl[11] = '{2, 30, 20, 1'b0};
      tbl[12] = '{2, 29, 21, 1'b0};
      tbl[13] = '{3, 30, 20, 1'b1};
      tbl[14] = '{3, 0, 0, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(negedge app_clk);
      chk_zero_outputs("rst");
      rst_n = 1'b1;

      for (int p = 0; p < 4; p++) begin
         set_pat(p);
         run_frame(-1, -1);
         for (int i = 0; i < 15; i++)
            if (tbl[i].pat == p)
               chk($sformatf("tbl%0d", i),
                   int'(out_img[tbl[i].y][tbl[i].x]), int'(tbl[i].px));
`ifdef MASK_FILTER_STATS_EN
         chk($sformatf("fgcnt_pat%0d", p), int'(fg_count), stat_exp[p]);
`endif
      end

      set_pat(4);
      run_frame(V / 2, H / 2);
      run_frame(-1, -1);
`ifdef MASK_FILTER_STATS_EN
      chk("fgcnt_rand", int'(fg_count), gold_count());
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fg_mask_filter.md
# fg_mask_filter

Streaming 3x3 majority filter for the 1-bit foreground mask. Sits between `background_substractor` (its `foreground` output) and `blob_analyzer` (its `foregnd_px` input), in the 25 MHz pixel domain. It removes isolated noise pixels and fills pinholes before blob labelling, using two 1-bit line buffers. It emits the filtered pixel with its own coordinates so that the downstream stage can align to them.

## Interface
Parameters:
- `H_RES`, 640, active pixels per line
- `V_RES`, 480, active lines per frame
- `THRESH`, 5, minimum number of set pixels among the 9 window pixels for the output to be 1 (range 1..9)

Ports:
- `app_clk` in 1: pixel clock (25 MHz), the only clock
- `rst_n` in 1: asynchronous, active-low reset
- `vid_active_pix` in 1: input pixel valid
- `vid_hpos` in 11: input column, 0..H_RES-1
- `vid_vpos` in 11: input row, 0..V_RES-1
- `foregnd_px` in 1: raw mask bit at (`vid_hpos`, `vid_vpos`)
- `filt_valid` out 1: filtered pixel valid
- `filt_px` out 1: filtered mask bit
- `filt_hpos` out 11: column of the filtered pixel
- `filt_vpos` out 11: row of the filtered pixel
- `fg_count` out 19: foreground pixel count of the previous frame (present only with `MASK_FILTER_STATS_EN`)

## Operation
Line buffers:
- `lb1[H_RES]` holds row y-1 and `lb2[H_RES]` holds row y-2.
- On every active cycle at column x:
  - read `lb2[x]` (top), `lb1[x]` (middle) and `foregnd_px` (bottom);
  - write `lb2[x]<=lb1[x]` and `lb1[x]<=foregnd_px`.
- Out-of-frame rows read as 0:
  - top is forced to 0 when `vid_vpos<2`;
  - middle is forced to 0 when `vid_vpos<1`.
- Buffers are not cleared by reset; this gating makes their contents irrelevant.
- An input with `vid_hpos>=H_RES` is ignored: no write and no output.

Window:
- A 3x3 bit shift register (3 columns x 3 rows) is centred on (x-1, y-1).
- On an active cycle the new column shifts in.
- On an active cycle with `vid_hpos==0`, the two older columns are cleared first, so the left neighbours of column 0 are 0.
- Flush cycle: the first inactive cycle after an active pixel with `vid_hpos==H_RES-1`. It shifts in an all-zero column so that centre column H_RES-1 is produced.

Output:
- `filt_px = (popcount(window) >= THRESH)`.
- `filt_valid` is produced:
  - on active inputs with `vid_hpos>=1` and `vid_vpos>=1`;
  - on the flush cycle, when `vid_vpos>=1`.
- Output coordinates:
  - `filt_hpos` is x-1, or H_RES-1 on the flush cycle;
  - `filt_vpos` is y-1.
- Consequences:
  - output rows are 0..V_RES-2;
  - row V_RES-1 is never emitted, and downstream treats it as background;
  - each emitted row carries exactly H_RES pixels.

## Timing
- All outputs are registered.
- Latency: an input sampled at edge n drives its output at edge n+1.
- Example: input (x=1, y=1) at edge n gives `filt_valid=1`, output (0,0) after edge n+1.
- Flush: the last active input (H_RES-1, y) is at edge n. The output (H_RES-2, y-1) appears after n+1 and the flush output (H_RES-1, y-1) after n+2.
- Horizontal blanking must be at least 1 cycle.
- Reset values: `filt_valid=0`, `filt_px=0`, `filt_hpos=0`, `filt_vpos=0`, `fg_count=0`; the window is cleared.
- Reset mid-frame:
  - outputs go to 0 asynchronously;
  - after release, the first valid output requires a new active pixel;
  - rows after reset may use stale line-buffer data until the next frame. This is accepted and is not an error.
- `vid_active_pix` low with no pending flush: `filt_valid=0`, and the window and coordinates hold.

## Configuration
`MASK_FILTER_STATS_EN`:
- Defined:
  - a 19-bit counter increments on every output with `filt_valid && filt_px`;
  - on the output for (H_RES-1, V_RES-2), the count including that pixel is latched into `fg_count` and the counter is cleared;
  - the counter saturates at 2^19-1.
- Undefined: there is no counter, and the `fg_count` port is absent.

## Test plan
- All-ones frame (640x480):
  - output rows 0..478, 640 valid pixels per row;
  - (0,0) and (639,0) are 0, since only 4 of 9 pixels are set;
  - all other pixels are 1;
  - with stats, `fg_count=306558`.
- Isolated pixel at (200,100) in a zero frame: no output is ever 1.
- Solid 3x3 block at columns 100..102, rows 50..52:
  - (101,51) is 1 (count 9);
  - (101,50) is 1 (count 6);
  - (100,50) is 0 (count 4);
  - (99,51) is 0 (count 3).
- Latency check: input (1,1) at edge n gives `filt_valid` after n+1 with (0,0); the flush output (639, y-1) appears 2 cycles after input (639, y).
- Pinhole: ones everywhere except (300,200); with `THRESH=5`, (300,200) outputs 1.
- Assert `rst_n=0` during row 240, column 320:
  - all outputs are 0 asynchronously;
  - after release, output restarts at the next active pixel with correct coordinates;
  - the next full frame matches the golden model.
